// File: rtl/axil_master_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port among NUM_REQ command requesters.
// Optional response watchdog: define AXIL_ARB_TIMEOUT_EN to enable it.
module axil_master_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wstrb,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic [ADDR_WIDTH-1:0]           M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]           M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]         M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]           M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]           M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_WIDTH != 32 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("axil_master_arbiter: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ADDR, S_WR_RESP, S_RD_ADDR, S_RD_RESP, S_DONE
  } state_e;

  state_e                  state_q;
  logic [IDX_W-1:0]        ptr_q, sel_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q, rsp_rdata_q;
  logic [STRB_W-1:0]       wstrb_q;
  logic                    awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic [NUM_REQ-1:0]      rsp_valid_q;
  logic [1:0]              rsp_resp_q;
  logic [IDX_W-1:0]        win_c, nxt_ptr_c;
  logic                    win_vld_c, timeout_c;
  logic [NUM_REQ-1:0]      sel_oh_c;

  // First pending requester at or above the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    win_c     = '0;
    win_vld_c = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      int idx;
      idx = int'(ptr_q) + i;
      if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
      if (!win_vld_c && req_valid[IDX_W'(idx)]) begin
        win_vld_c = 1'b1;
        win_c     = IDX_W'(idx);
      end
    end
  end

  assign nxt_ptr_c = (win_c == IDX_W'(NUM_REQ - 1)) ? '0 : win_c + 1'b1;
  assign sel_oh_c  = NUM_REQ'(1) << sel_q;
  assign req_ready = (ARESETN && state_q == S_IDLE && win_vld_c) ? (NUM_REQ'(1) << win_c) : '0;

`ifdef AXIL_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q;
  logic             busy_c;

  assign busy_c = (state_q == S_WR_ADDR) || (state_q == S_WR_RESP) ||
                  (state_q == S_RD_ADDR) || (state_q == S_RD_RESP);

  // Cleared while idle, so it restarts from zero on every new grant.
  always_ff @(posedge ACLK) begin
    if (!ARESETN)                cnt_q <= '0;
    else if (state_q == S_IDLE)  cnt_q <= '0;
    else if (busy_c)             cnt_q <= cnt_q + 1'b1;
  end

  assign timeout_c = busy_c && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_c = 1'b0;
`endif

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      sel_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else if (timeout_c) begin
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= sel_oh_c;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b10;
      state_q     <= S_DONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_vld_c) begin
            sel_q   <= win_c;
            ptr_q   <= nxt_ptr_c;
            addr_q  <= req_addr[win_c*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_q <= req_wdata[win_c*DATA_WIDTH +: DATA_WIDTH];
            wstrb_q <= req_wstrb[win_c*STRB_W +: STRB_W];
            if (req_wr[win_c]) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= S_WR_ADDR;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= S_RD_ADDR;
            end
          end
        end
        // AW and W channels complete independently, in either order.
        S_WR_ADDR: begin
          if (M_AXI_AWREADY) awvalid_q <= 1'b0;
          if (M_AXI_WREADY)  wvalid_q  <= 1'b0;
          if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY)) begin
            bready_q <= 1'b1;
            state_q  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (M_AXI_BVALID) begin
            bready_q    <= 1'b0;
            rsp_valid_q <= sel_oh_c;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= M_AXI_BRESP;
            state_q     <= S_DONE;
          end
        end
        S_RD_ADDR: begin
          if (M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RD_RESP;
          end
        end
        S_RD_RESP: begin
          if (M_AXI_RVALID) begin
            rready_q    <= 1'b0;
            rsp_valid_q <= sel_oh_c;
            rsp_rdata_q <= M_AXI_RDATA;
            rsp_resp_q  <= M_AXI_RRESP;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          rsp_valid_q <= '0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
endmodule

// File: tb/tb_axil_master_arbiter.sv
// Directed bench for axil_master_arbiter with a 4-word AXI4-Lite slave model.
`timescale 1ns/1ps
module tb_axil_master_arbiter;
  localparam int unsigned N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [N-1:0]  req_valid, req_ready, req_wr, rsp_valid;
  logic [N*32-1:0] req_addr, req_wdata;
  logic [N*4-1:0]  req_wstrb;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [31:0]   awaddr, wdata, araddr;
  logic [2:0]    awprot, arprot;
  logic [3:0]    wstrb;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [31:0]   s_rdata;

  // Slave-model controls driven by the stimulus
  logic          aw_rdy_en, ar_rdy_en, rd_hold;
  logic [1:0]    rsp_code;

  assign awready = aw_rdy_en;
  assign wready  = 1'b1;
  assign arready = ar_rdy_en;

  axil_master_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(rsp_code), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(s_rdata), .M_AXI_RRESP(rsp_code), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  // Slave: word memory indexed by addr[3:2]; B/R responses one cycle after the handshakes.
  logic [31:0] mem [0:3] = '{32'h0, 32'h0, 32'h0, 32'h0};
  logic        aw_got, w_got;
  logic [31:0] aw_a, w_d;
  int          bcnt;
  always @(posedge clk) begin
    logic [31:0] a_t, d_t;
    if (!rst_n) begin
      bvalid <= 1'b0; rvalid <= 1'b0; s_rdata <= '0;
      aw_got <= 1'b0; w_got <= 1'b0; aw_a <= '0; w_d <= '0; bcnt <= 0;
    end else begin
      a_t = aw_got ? aw_a : awaddr;
      d_t = w_got ? w_d : wdata;
      if (awvalid && awready) begin aw_got <= 1'b1; aw_a <= awaddr; end
      if (wvalid && wready)   begin w_got <= 1'b1;  w_d <= wdata;   end
      if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready)) && !bvalid) begin
        mem[a_t[3:2]] <= d_t;
        bvalid <= 1'b1;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (bvalid && bready) begin bvalid <= 1'b0; bcnt <= bcnt + 1; end
      if (arvalid && arready && !rd_hold) begin rvalid <= 1'b1; s_rdata <= mem[araddr[3:2]]; end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // Tracks how many AXI transactions are in flight at once.
  int outst = 0, max_outst = 0;
  always @(posedge clk) begin
    if (!rst_n) outst <= 0;
    else begin
      outst <= outst + int'((arvalid && arready) || (awvalid && awready))
                     - int'((rvalid && rready) || (bvalid && bready));
      if (outst > max_outst) max_outst <= outst;
    end
  end

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present a command on requester r and return just after the grant edge.
  task automatic issue(input int r, input logic wr, input logic [31:0] a, input logic [31:0] d);
    int n;
    @(negedge clk);
    req_wr[r] = wr;
    req_addr[r*32 +: 32] = a;
    req_wdata[r*32 +: 32] = d;
    req_wstrb[r*4 +: 4] = 4'hF;
    req_valid[r] = 1'b1;
    #1;
    n = 0;
    while (req_ready[r] !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
    chk("grant_wait", 32'(n < 50), 32'd1);
    chk("req_ready_onehot", 32'(req_ready), 32'(1 << r));
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  // Wait for rsp_valid; lat counts negedges since the grant edge (lat0 already consumed).
  task automatic wait_rsp(input int r, input int lat0, output logic [31:0] rd, output logic [1:0] rs,
                          output int lat);
    lat = lat0;
    while (rsp_valid == '0 && lat < 100) begin @(negedge clk); lat++; end
    chk("rsp_valid_target", 32'(rsp_valid), 32'(1 << r));
    rd = rsp_rdata;
    rs = rsp_resp;
    @(negedge clk);
    chk("rsp_valid_one_cycle", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs;
    int          lat, b0;

    rst_n = 1'b0; req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    aw_rdy_en = 1'b1; ar_rdy_en = 1'b1; rd_hold = 1'b0; rsp_code = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    req_valid = 2'b11;
    #1;
    chk("rst_axi_vr", 32'({awvalid, wvalid, bready, arvalid, rready}), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp", 32'({rsp_valid, rsp_resp}), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("prot_zero", 32'({awprot, arprot}), 32'd0);
    req_valid = '0;
    rst_n = 1'b1;

    // Both requesters hold valid: grants alternate 0,1,0,1 starting from pointer 0.
    @(negedge clk);
    req_wr = '0; req_addr = {32'h4, 32'h0};
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("arb_grant", 32'(req_ready), 32'(1 << (k % 2)));
      @(posedge clk); #1;
      wait_rsp(k % 2, 0, rd, rs, lat);
      chk("arb_latency", 32'(lat), 32'd3);
    end
    req_valid = '0;
    chk("arb_single_outstanding", 32'(max_outst <= 1), 32'd1);

    // Zero-wait write: AW/W one cycle after grant, response 3 cycles after grant.
    issue(0, 1'b1, 32'h0, 32'h1);
    @(negedge clk);
    chk("wr_aw_w_valid", 32'({awvalid, wvalid}), 32'd3);
    chk("wr_awaddr", awaddr, 32'h0);
    chk("wr_wdata", wdata, 32'h1);
    chk("wr_wstrb", 32'(wstrb), 32'hF);
    wait_rsp(0, 1, rd, rs, lat);
    chk("wr_latency", 32'(lat), 32'd3);
    chk("wr_resp", 32'(rs), 32'd0);

    for (int i = 0; i < 4; i++) begin
      issue(1, 1'b1, 32'(4 * i), 32'(i + 1));
      wait_rsp(1, 0, rd, rs, lat);
      chk("wr_seq_resp", 32'(rs), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      issue(0, 1'b0, 32'(4 * i), 32'h0);
      wait_rsp(0, 0, rd, rs, lat);
      chk("rd_seq_data", rd, 32'(i + 1));
      chk("rd_seq_resp", 32'(rs), 32'd0);
      chk("rd_seq_latency", 32'(lat), 32'd3);
    end

    // WREADY two cycles before AWREADY.
    aw_rdy_en = 1'b0;
    b0 = bcnt;
    issue(0, 1'b1, 32'h8, 32'h33);
    @(negedge clk);
    chk("split_c1_valids", 32'({awvalid, wvalid}), 32'd3);
    @(negedge clk);
    chk("split_c2_valids", 32'({awvalid, wvalid}), 32'd2);
    chk("split_c2_awaddr", awaddr, 32'h8);
    @(negedge clk);
    chk("split_c3_valids", 32'({awvalid, wvalid}), 32'd2);
    chk("split_c3_awaddr", awaddr, 32'h8);
    aw_rdy_en = 1'b1;
    wait_rsp(0, 3, rd, rs, lat);
    chk("split_latency", 32'(lat), 32'd5);
    chk("split_resp", 32'(rs), 32'd0);
    chk("split_b_handshakes", 32'(bcnt - b0), 32'd1);
    chk("split_mem", mem[2], 32'h33);

    // Slave error codes pass through; write response data is zero.
    rsp_code = 2'b10;
    issue(1, 1'b1, 32'hC, 32'h44);
    wait_rsp(1, 0, rd, rs, lat);
    chk("bresp_pass", 32'(rs), 32'd2);
    chk("wr_rdata_zero", rd, 32'd0);
    rsp_code = 2'b11;
    issue(1, 1'b0, 32'hC, 32'h0);
    wait_rsp(1, 0, rd, rs, lat);
    chk("rresp_pass", 32'(rs), 32'd3);
    chk("rresp_data", rd, 32'h44);
    rsp_code = 2'b00;

    // Reset while waiting for RVALID abandons the read.
    rd_hold = 1'b1;
    issue(0, 1'b0, 32'h4, 32'h0);
    @(negedge clk);
    chk("rst_mid_arvalid", 32'(arvalid), 32'd1);
    @(negedge clk);
    chk("rst_mid_rready", 32'({arvalid, rready}), 32'd1);
    rst_n = 1'b0;
    req_valid = 2'b01;
    @(posedge clk); #1;
    chk("rst_mid_axi_vr", 32'({awvalid, wvalid, bready, arvalid, rready}), 32'd0);
    chk("rst_mid_req_ready", 32'(req_ready), 32'd0);
    chk("rst_mid_rsp", 32'({rsp_valid, rsp_resp}), 32'd0);
    chk("rst_mid_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_hold = 1'b0;
    req_wr = '0; req_addr = {32'h0, 32'h4};
    req_valid = 2'b11;
    #1;
    chk("post_rst_ptr0", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(0, 0, rd, rs, lat);
    chk("post_rst_data", rd, 32'h2);
    chk("post_rst_resp", 32'(rs), 32'd0);
    chk("post_rst_latency", 32'(lat), 32'd3);

`ifdef AXIL_ARB_TIMEOUT_EN
    // Slave never accepts AR: 16 busy cycles, then DONE with SLVERR.
    ar_rdy_en = 1'b0;
    issue(0, 1'b0, 32'hC, 32'h0);
    wait_rsp(0, 0, rd, rs, lat);
    chk("to_latency", 32'(lat), 32'd17);
    chk("to_resp", 32'(rs), 32'd2);
    chk("to_rdata", rd, 32'd0);
    chk("to_arvalid_dropped", 32'(arvalid), 32'd0);
    ar_rdy_en = 1'b1;
    issue(0, 1'b0, 32'hC, 32'h0);
    wait_rsp(0, 0, rd, rs, lat);
    chk("to_recover_resp", 32'(rs), 32'd0);
    chk("to_recover_data", rd, 32'h44);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axil_master_arbiter.md
Name: axil_master_arbiter

Overview:
- Shares one AXI4-Lite master port between NUM_REQ simple command requesters (e.g. config sequencer, debug/host bridge).
- Each requester gets its own register-access port, so several can program the same AXI4-Lite slave register file.
- Round-robin arbitration; one outstanding AXI transaction at a time.
- Sits between the requesters and the AXI4-Lite slave register block.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width (32 only).
- TIMEOUT_CYCLES, 256, response watchdog limit. Used only with the optional feature.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  command valid, one bit per requester.
- req_ready  out  NUM_REQ  command accepted, one bit per requester.
- req_wr  in  NUM_REQ  1=write, 0=read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_wstrb  in  NUM_REQ*DATA_WIDTH/8  packed byte strobes.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse; no backpressure.
- rsp_rdata  out  DATA_WIDTH  read data; valid with rsp_valid.
- rsp_resp  out  2  AXI response code; valid with rsp_valid.
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARPROT/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY:
  - standard AXI4-Lite master signals.
  - AWPROT/ARPROT tied to 3'b000.

Behaviour:
- Reset (ARESETN low at a rising ACLK edge):
  - state=IDLE, round-robin pointer=0.
  - All AXI VALID/READY outputs 0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_resp=0.
  - Reset mid-transaction abandons it; no rsp_valid is issued for it.
- States: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_RESP, DONE.
- IDLE:
  - req_ready[g] is combinational, high only for the winner g.
  - g = first i with req_valid[i]=1, searching from the pointer upward modulo NUM_REQ.
  - On that edge: capture wr/addr/wdata/wstrb of g; pointer<=(g+1) mod NUM_REQ.
  - Go to WR_ADDR if wr, else RD_ADDR.
  - No request pending: stay in IDLE, req_ready=0.
- WR_ADDR:
  - Assert AWVALID and WVALID together on the cycle after the grant.
  - Each drops independently on the edge where its READY is seen.
  - Both handshakes complete (same or different cycles) -> WR_RESP.
  - Address and data stay stable while their VALID is high.
- WR_RESP: BREADY=1. On BVALID, capture BRESP, rdata<=0 -> DONE.
- RD_ADDR: ARVALID=1 until ARREADY -> RD_RESP.
- RD_RESP: RREADY=1. On RVALID, capture RDATA/RRESP -> DONE.
- DONE:
  - rsp_valid[g]=1 for exactly one cycle; rsp_rdata/rsp_resp registered.
  - -> IDLE. The next grant can occur in the IDLE cycle that follows.
- Minimum latency with zero-wait slave, from grant edge to rsp_valid: 3 cycles (addr, resp, done).
- Requesters must hold req_valid and payload stable until req_ready.
- rsp_valid is never asserted to a non-granted requester.
- A requester may re-request immediately. Round-robin guarantees every other pending requester is served first.
- Slave responses (BRESP/RRESP) are passed through unmodified.

Optional Feature:
- Macro: AXIL_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entering WR_ADDR or RD_ADDR and increments each cycle in WR_ADDR/WR_RESP/RD_ADDR/RD_RESP.
  - At TIMEOUT_CYCLES-1: drop all AXI VALID/READY, go to DONE with rsp_resp=2'b10 (SLVERR), rsp_rdata=0.
  - The arbiter then stays usable.
- Undefined: no counter; the arbiter waits indefinitely for the slave.

Test Plan:
- req0 write addr 0x0 data 0x00000001 wstrb 0xF; slave zero-wait -> AWVALID/WVALID asserted 1 cycle after req_ready[0]; rsp_valid[0] 3 cycles after grant, resp 2'b00.
- Write 0x1..0x4 to 0x0,0x4,0x8,0xC via req1, then read the same addresses via req0 -> rsp_rdata = 0x1,0x2,0x3,0x4, resp 2'b00.
- req0 and req1 both valid continuously for 4 transactions -> grant order 0,1,0,1; never two outstanding AXI transactions.
- Slave asserts WREADY 2 cycles before AWREADY -> WVALID drops first, AWVALID held with stable AWADDR; one BREADY handshake; single rsp_valid.
- ARESETN low during RD_RESP -> all outputs 0 next edge; no rsp_valid; a new req0 read after reset completes normally from pointer 0.
- With AXIL_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never asserts ARREADY -> rsp_valid with resp 2'b10 after 16 cycles; a following read to a responsive slave returns 2'b00.
